math_pipelined_sub: RTL and testbench



---
 rtl/math_pipelined_sub_if.sv | 23 ++
 rtl/math_pipelined_sub.sv | 112 +++++++++++
 tb/tb_math_pipelined_sub.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/math_pipelined_sub_if.sv
// Start/result handshake bundle for the chunked subtractor.
// The master drives the operands and ce; the slave returns the result and status.
interface math_pipelined_sub_if #(
    parameter int unsigned WIDTH = 4
);
    logic             ce;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] i;
    logic [WIDTH-1:0] q;
    logic             underflow;
    logic             valid;
    logic             busy;

    modport master (
        output ce, d, i,
        input  q, underflow, valid, busy
    );

    modport slave (
        input  ce, d, i,
        output q, underflow, valid, busy
    );
endinterface

// File: rtl/math_pipelined_sub.sv
// Multi-cycle subtractor: q = d - i mod 2^WIDTH, one ALU_WIDTH-bit chunk per clock,
// LSB chunk first, with the borrow carried between chunks in a register.
module math_pipelined_sub #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    math_pipelined_sub_if.slave  bus
);
    localparam int unsigned ALU_WIDTH   = (WIDTH + LATENCY - 1) / LATENCY;
    localparam int unsigned CHUNK_COUNT = (WIDTH + ALU_WIDTH - 1) / ALU_WIDTH;
    localparam int unsigned PAD_W       = CHUNK_COUNT * ALU_WIDTH;
    localparam int unsigned CHK_W       = ALU_WIDTH + 1;
    localparam int unsigned CNT_W       = (CHUNK_COUNT > 1) ? $clog2(CHUNK_COUNT) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             accept_c;
    logic             step_c;
    logic             last_c;

    // Operands are zero-padded to whole chunks; the padded top bits of the last
    // chunk leave its borrow-out identical to that of the real LAST_CHUNK_SIZE bits.
    logic [PAD_W-1:0] r_min;
    logic [PAD_W-1:0] r_sub;
    logic [PAD_W-1:0] r_diff;
    logic [PAD_W-1:0] diff_next_c;
    logic             r_borrow;
    logic [CNT_W-1:0] k;
    logic [CHK_W-1:0] chunk_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.ce) state_next = RUN;
            RUN:     if (last_c) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        accept_c = 1'b0;
        step_c   = 1'b0;
        last_c   = (k == CNT_W'(CHUNK_COUNT - 1));
        case (state)
            IDLE:    accept_c = bus.ce;
            RUN:     step_c   = 1'b1;
            default: ;
        endcase
    end

    // The only subtractor: the low chunk of the shifting operand registers.
    always_comb begin
        chunk_c     = {1'b0, r_min[ALU_WIDTH-1:0]}
                    - {1'b0, r_sub[ALU_WIDTH-1:0]}
                    - CHK_W'(r_borrow);
        diff_next_c = (r_diff >> ALU_WIDTH)
                    | (PAD_W'(chunk_c[ALU_WIDTH-1:0]) << (PAD_W - ALU_WIDTH));
    end

    // Datapath and registered outputs; results land only on the final chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_min         <= '0;
            r_sub         <= '0;
            r_diff        <= '0;
            r_borrow      <= 1'b0;
            k             <= '0;
            bus.q         <= '0;
            bus.underflow <= 1'b0;
            bus.valid     <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            bus.valid <= 1'b0;
            bus.busy  <= (state_next == RUN);
            if (accept_c) begin
                r_min    <= PAD_W'(bus.d);
                r_sub    <= PAD_W'(bus.i);
                r_borrow <= 1'b0;
                k        <= '0;
            end else if (step_c) begin
                r_min    <= r_min >> ALU_WIDTH;
                r_sub    <= r_sub >> ALU_WIDTH;
                r_diff   <= diff_next_c;
                r_borrow <= chunk_c[ALU_WIDTH];
                k        <= k + CNT_W'(1);
                if (last_c) begin
                    bus.q         <= diff_next_c[WIDTH-1:0];
                    bus.underflow <= chunk_c[ALU_WIDTH];
                    bus.valid     <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_math_pipelined_sub.sv
// Scoreboard bench for math_pipelined_sub over four parameter sets: directed
// borrow/underflow/busy/reset cases plus a long randomized run at WIDTH=13.
module tb_math_pipelined_sub;
    localparam int N  = 4;
    localparam int W0 = 8;
    localparam int L0 = 3;
    localparam int W1 = 13;
    localparam int L1 = 4;
    localparam int W2 = 4;
    localparam int L2 = 1;
    localparam int W3 = 4;
    localparam int L3 = 8;

    typedef struct {
        longint q;
        bit     uf;
        longint due;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_v [N];
    logic        ce_v  [N];
    logic [31:0] d_v   [N];
    logic [31:0] i_v   [N];
    logic [31:0] q_v   [N];
    logic        uf_v  [N];
    logic        val_v [N];
    logic        busy_v[N];

    exp_t   sb[N][$];
    longint last_q [N];
    bit     last_uf[N];
    longint free_edge[N];
    bit     started[N];
    longint edge_n = 0;
    int     n_checks = 0;
    int     n_pass   = 0;

    always #5 clk = ~clk;

    math_pipelined_sub_if #(.WIDTH(W0)) b0 ();
    math_pipelined_sub_if #(.WIDTH(W1)) b1 ();
    math_pipelined_sub_if #(.WIDTH(W2)) b2 ();
    math_pipelined_sub_if #(.WIDTH(W3)) b3 ();

    math_pipelined_sub #(.WIDTH(W0), .LATENCY(L0)) u0 (.clk(clk), .rst_n(rst_v[0]), .bus(b0.slave));
    math_pipelined_sub #(.WIDTH(W1), .LATENCY(L1)) u1 (.clk(clk), .rst_n(rst_v[1]), .bus(b1.slave));
    math_pipelined_sub #(.WIDTH(W2), .LATENCY(L2)) u2 (.clk(clk), .rst_n(rst_v[2]), .bus(b2.slave));
    math_pipelined_sub #(.WIDTH(W3), .LATENCY(L3)) u3 (.clk(clk), .rst_n(rst_v[3]), .bus(b3.slave));

    assign b0.ce = ce_v[0];  assign b0.d = d_v[0][W0-1:0];  assign b0.i = i_v[0][W0-1:0];
    assign b1.ce = ce_v[1];  assign b1.d = d_v[1][W1-1:0];  assign b1.i = i_v[1][W1-1:0];
    assign b2.ce = ce_v[2];  assign b2.d = d_v[2][W2-1:0];  assign b2.i = i_v[2][W2-1:0];
    assign b3.ce = ce_v[3];  assign b3.d = d_v[3][W3-1:0];  assign b3.i = i_v[3][W3-1:0];

    assign q_v[0] = 32'(b0.q);  assign uf_v[0] = b0.underflow;  assign val_v[0] = b0.valid;  assign busy_v[0] = b0.busy;
    assign q_v[1] = 32'(b1.q);  assign uf_v[1] = b1.underflow;  assign val_v[1] = b1.valid;  assign busy_v[1] = b1.busy;
    assign q_v[2] = 32'(b2.q);  assign uf_v[2] = b2.underflow;  assign val_v[2] = b2.valid;  assign busy_v[2] = b2.busy;
    assign q_v[3] = 32'(b3.q);  assign uf_v[3] = b3.underflow;  assign val_v[3] = b3.valid;  assign busy_v[3] = b3.busy;

    function automatic int width_of(int n);
        case (n)
            0:       return W0;
            1:       return W1;
            2:       return W2;
            default: return W3;
        endcase
    endfunction

    function automatic int lat_of(int n);
        case (n)
            0:       return L0;
            1:       return L1;
            2:       return L2;
            default: return L3;
        endcase
    endfunction

    // Cycles per operation straight from the chunking rules.
    function automatic int cc_of(int n);
        int alu;
        alu = (width_of(n) + lat_of(n) - 1) / lat_of(n);
        return (width_of(n) + alu - 1) / alu;
    endfunction

    function automatic longint mask_of(int n);
        return (longint'(1) << width_of(n)) - 1;
    endfunction

    task automatic check(input bit ok, input string name, input longint act, input longint exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, edge_n, act, exp);
    endtask

    // Reference model: decides accepts from the handshake rules and queues results.
    always @(posedge clk) begin
        edge_n++;
        for (int n = 0; n < N; n++) begin
            if (!rst_v[n]) begin
                sb[n].delete();
                last_q[n]    = 0;
                last_uf[n]   = 1'b0;
                free_edge[n] = 0;
                started[n]   = 1'b1;
            end else if (ce_v[n] && edge_n >= free_edge[n]) begin
                exp_t   e;
                longint dm;
                longint im;
                dm    = longint'(d_v[n]) & mask_of(n);
                im    = longint'(i_v[n]) & mask_of(n);
                e.q   = (dm - im) & mask_of(n);
                e.uf  = (dm < im);
                e.due = edge_n + cc_of(n);
                sb[n].push_back(e);
                free_edge[n] = edge_n + cc_of(n) + 1;
            end
        end
    end

    // Monitor: compares handshake status every cycle and results on valid.
    always @(posedge clk) begin
        #1;
        for (int n = 0; n < N; n++) begin
            if (started[n]) begin
                bit exp_valid;
                bit exp_busy;
                exp_valid = (sb[n].size() > 0) && (sb[n][0].due == edge_n);
                exp_busy  = (sb[n].size() > 0) && (sb[n][0].due >  edge_n);
                check({val_v[n], busy_v[n]} == {exp_valid, exp_busy},
                      $sformatf("dut%0d valid/busy", n),
                      longint'({val_v[n], busy_v[n]}), longint'({exp_valid, exp_busy}));
                if (exp_valid) begin
                    exp_t e;
                    e = sb[n].pop_front();
                    check(longint'(q_v[n]) == e.q, $sformatf("dut%0d q", n), longint'(q_v[n]), e.q);
                    check(uf_v[n] == e.uf, $sformatf("dut%0d underflow", n), longint'(uf_v[n]), longint'(e.uf));
                    last_q[n]  = e.q;
                    last_uf[n] = e.uf;
                end else begin
                    check((longint'(q_v[n]) == last_q[n]) && (uf_v[n] == last_uf[n]),
                          $sformatf("dut%0d q/underflow hold", n),
                          longint'(q_v[n]) * 2 + longint'(uf_v[n]), last_q[n] * 2 + longint'(last_uf[n]));
                end
            end
        end
    end

    // One operation: accept, scramble inputs mid-flight, wait out the latency.
    task automatic op(input int n, input longint d, input longint i);
        @(negedge clk);
        ce_v[n] = 1'b1;
        d_v[n]  = 32'(d & mask_of(n));
        i_v[n]  = 32'(i & mask_of(n));
        @(negedge clk);
        ce_v[n] = 1'b0;
        d_v[n]  = 32'($urandom) & 32'(mask_of(n));
        i_v[n]  = 32'($urandom) & 32'(mask_of(n));
        repeat (cc_of(n) + 1) @(negedge clk);
    endtask

    // ce held high with inputs changing every cycle: back-to-back operation.
    task automatic hold_ce(input int n, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            ce_v[n] = 1'b1;
            d_v[n]  = 32'($urandom) & 32'(mask_of(n));
            i_v[n]  = 32'($urandom) & 32'(mask_of(n));
        end
        @(negedge clk);
        ce_v[n] = 1'b0;
        repeat (cc_of(n) + 1) @(negedge clk);
    endtask

    // Reset asserted one cycle after accept: the in-flight result is dropped.
    task automatic reset_mid_op(input int n);
        @(negedge clk);
        ce_v[n] = 1'b1;
        d_v[n]  = 32'h5 & 32'(mask_of(n));
        i_v[n]  = 32'h3 & 32'(mask_of(n));
        @(negedge clk);
        ce_v[n]  = 1'b0;
        rst_v[n] = 1'b0;
        @(negedge clk);
        rst_v[n] = 1'b1;
        repeat (cc_of(n) + 2) @(negedge clk);
    endtask

    initial begin
        for (int n = 0; n < N; n++) begin
            rst_v[n]     = 1'b0;
            ce_v[n]      = 1'b0;
            d_v[n]       = '0;
            i_v[n]       = '0;
            last_q[n]    = 0;
            last_uf[n]   = 1'b0;
            free_edge[n] = 0;
            started[n]   = 1'b0;
        end
        repeat (2) @(negedge clk);
        for (int n = 0; n < N; n++) rst_v[n] = 1'b1;

        fork
            begin
                reset_mid_op(0);
                op(0, 'h50, 'h01);
                op(0, 'h40, 'h01);
                op(0, 'h00, 'h01);
                op(0, 'h7F, 'h7F);
                op(0, 'hFF, 'h00);
                op(0, 'h00, 'hFF);
                hold_ce(0, 13);
                reset_mid_op(2);
                op(2, 3, 5);
                op(2, 5, 3);
                op(2, 0, 15);
                hold_ce(2, 9);
                op(3, 3, 5);
                op(3, 8, 7);
                hold_ce(3, 11);
                for (int k = 0; k < 100; k++) op(3, longint'($urandom), longint'($urandom));
            end
            begin
                for (int c = 0; c < 10000; c++) begin
                    @(negedge clk);
                    ce_v[1]  = ($urandom_range(0, 3) != 0);
                    d_v[1]   = 32'($urandom) & 32'(mask_of(1));
                    i_v[1]   = 32'($urandom) & 32'(mask_of(1));
                    case ($urandom_range(0, 7))
                        0:       i_v[1] = d_v[1];
                        1:       d_v[1] = '0;
                        2:       i_v[1] = '0;
                        default: ;
                    endcase
                    rst_v[1] = ($urandom_range(0, 299) != 0);
                end
                @(negedge clk);
                ce_v[1]  = 1'b0;
                rst_v[1] = 1'b1;
            end
        join

        repeat (8) @(negedge clk);
        for (int n = 0; n < N; n++)
            check(sb[n].size() == 0, $sformatf("dut%0d results outstanding", n),
                  longint'(sb[n].size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
